// File: rtl/network_meta_decouple.sv
// Per-channel metadata decoupling: each channel is either a registered FIFO or a
// last-value-wins holding register. Optional stats passthrough under NET_META_STATS_EN.

module network_meta_decouple_lane #(
  parameter int DATA_BITS = 48,
  parameter int DEPTH     = 4,
  parameter bit COAL      = 1'b0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_BITS-1:0]      s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_BITS-1:0]      m_data,
  output logic [$clog2(DEPTH):0]    m_occ,
  output logic                      m_ovr
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  if (!COAL) begin : g_fifo
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OW-1:0]        occ_q, occ_d;
    logic                 push, pop;

    // s_ready depends only on registered occupancy (and reset), never on m_ready
    assign s_ready = aresetn && (occ_q < OW'(DEPTH));
    assign push    = s_valid & s_ready;
    assign m_valid = (occ_q != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = mem_q[rptr_q];
    assign m_occ   = occ_q;
    assign m_ovr   = 1'b0;

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      occ_d = occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        occ_q  <= occ_d;
      end
    end

    always_ff @(posedge aclk) begin
      if (push) mem_q[wptr_q] <= s_data;
    end
  end else begin : g_coal
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 vld_q, vld_d, ovr_q, ovr_d;
    logic                 push, pop;

    assign s_ready = aresetn;
    assign push    = s_valid & aresetn;
    assign pop     = vld_q & m_ready;
    assign m_valid = vld_q;
    assign m_data  = data_q;
    assign m_occ   = OW'(vld_q);
    assign m_ovr   = ovr_q;

    // A push that meets a pop hands off cleanly; only an unconsumed value is overwritten
    always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      ovr_d  = 1'b0;
      if (push) begin
        data_d = s_data;
        vld_d  = 1'b1;
        ovr_d  = vld_q & ~pop;
      end else if (pop) begin
        vld_d  = 1'b0;
      end
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        data_q <= '0;
        vld_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
        ovr_q  <= ovr_d;
      end
    end
  end
endmodule

module network_meta_decouple #(
  parameter int                N_CHAN    = 3,
  parameter int                DATA_BITS = 48,
  parameter int                DEPTH     = 4,
  parameter logic [N_CHAN-1:0] COALESCE  = '0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [N_CHAN-1:0]                    s_valid,
  output logic [N_CHAN-1:0]                    s_ready,
  input  logic [N_CHAN*DATA_BITS-1:0]          s_data,
  output logic [N_CHAN-1:0]                    m_valid,
  input  logic [N_CHAN-1:0]                    m_ready,
  output logic [N_CHAN*DATA_BITS-1:0]          m_data,
  output logic [N_CHAN*($clog2(DEPTH)+1)-1:0]  m_occ,
`ifdef NET_META_STATS_EN
  output logic [N_CHAN-1:0]                    m_ovr,
  input  logic [511:0]                         s_stats,
  output logic [511:0]                         m_stats
`else
  output logic [N_CHAN-1:0]                    m_ovr
`endif
);
  localparam int OW = $clog2(DEPTH) + 1;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_lane
    network_meta_decouple_lane #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH),
      .COAL      (COALESCE[i])
    ) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_valid (s_valid[i]),
      .s_ready (s_ready[i]),
      .s_data  (s_data[i*DATA_BITS +: DATA_BITS]),
      .m_valid (m_valid[i]),
      .m_ready (m_ready[i]),
      .m_data  (m_data[i*DATA_BITS +: DATA_BITS]),
      .m_occ   (m_occ[i*OW +: OW]),
      .m_ovr   (m_ovr[i])
    );
  end

`ifdef NET_META_STATS_EN
  logic [511:0] stats_q;
  always_ff @(posedge aclk) begin
    if (!aresetn) stats_q <= '0;
    else          stats_q <= s_stats;
  end
  assign m_stats = stats_q;
`endif
endmodule

// File: tb/tb_network_meta_decouple.sv
// Directed bench: FIFO fill/drain with wrap, coalescing overwrite and handoff,
// mid-run reset, and stats passthrough when NET_META_STATS_EN is defined.
module tb_network_meta_decouple;
  logic         aclk = 1'b0;
  logic         aresetn;
  logic [2:0]   s_valid, s_ready, m_valid, m_ready, m_ovr;
  logic [143:0] s_data, m_data;
  logic [8:0]   m_occ;
`ifdef NET_META_STATS_EN
  logic [511:0] s_stats, m_stats;
`endif

  int checks = 0;
  int fails  = 0;
  int n, novr, ndel;
  logic acc;

  always #5 aclk = ~aclk;

  network_meta_decouple #(
    .N_CHAN(3), .DATA_BITS(48), .DEPTH(4), .COALESCE(3'b010)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_occ(m_occ),
`ifdef NET_META_STATS_EN
    .m_ovr(m_ovr), .s_stats(s_stats), .m_stats(m_stats)
`else
    .m_ovr(m_ovr)
`endif
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  initial begin
    aresetn = 1'b0; s_valid = '0; s_data = '0; m_ready = '0;
`ifdef NET_META_STATS_EN
    s_stats = '0;
`endif
    step(); step();
    @(negedge aclk);
    chk("rst_s_ready", s_ready, 3'b000);
    chk("rst_m_valid", m_valid, 3'b000);
    chk("rst_m_occ",   m_occ,   9'd0);
    chk("rst_m_ovr",   m_ovr,   3'b000);
    step(); aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_s_ready", s_ready, 3'b111);

    // FIFO fill: 0x11..0x14 accepted, 0x15 refused
    for (int k = 0; k < 5; k++) begin
      step(); s_valid[0] = 1'b1; s_data[47:0] = 48'h11 + 48'(k);
      @(negedge aclk);
      chk($sformatf("fill_rdy%0d", k), s_ready[0], (k < 4) ? 1'b1 : 1'b0);
    end
    chk("full_occ",   m_occ[2:0],   3'd4);
    chk("full_head",  m_data[47:0], 48'h11);

    // FIFO drain with wrap; 0x15 enters once a slot frees
    step(); m_ready[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (c == 0) chk("full_rdy_same", s_ready[0], 1'b0);
      if (c == 1) chk("full_rdy_next", s_ready[0], 1'b1);
      if (c == 2) chk("occ_pushpop",   m_occ[2:0], 3'd3);
      acc = s_valid[0] & s_ready[0];
      if (m_valid[0]) begin
        chk($sformatf("order%0d", n), m_data[47:0], 48'h11 + 48'(n));
        chk($sformatf("b2b%0d", n), c, n);
        n++;
      end
      step();
      if (acc) s_valid[0] = 1'b0;
    end
    chk("fifo_count", n, 5);
    chk("fifo_empty_occ", m_occ[2:0], 3'd0);
    m_ready = '0;

    // Coalescing overwrite: A,B,C back-to-back with no pop
    novr = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      s_valid[1] = (k < 3);
      s_data[95:48] = 48'hA + 48'(k);
      @(negedge aclk);
      chk($sformatf("coal_rdy%0d", k), s_ready[1], 1'b1);
      chk($sformatf("ovr_fifo%0d", k), m_ovr & 3'b101, 3'b000);
      if (m_ovr[1]) novr++;
    end
    chk("coal_ovr_cnt", novr, 2);
    chk("coal_occ",     m_occ[5:3], 3'd1);
    step(); m_ready[1] = 1'b1;
    ndel = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      if (m_valid[1]) begin
        chk("coal_word", m_data[95:48], 48'hC);
        ndel++;
      end
      step();
    end
    chk("coal_del_cnt", ndel, 1);
    m_ready[1] = 1'b0;

    // Coalescing handoff: push B while popping A
    s_valid[1] = 1'b1; s_data[95:48] = 48'hA;
    step(); s_valid[1] = 1'b1; s_data[95:48] = 48'hB; m_ready[1] = 1'b1;
    @(negedge aclk);
    chk("hand_vld_a", m_valid[1], 1'b1);
    chk("hand_dat_a", m_data[95:48], 48'hA);
    step(); s_valid[1] = 1'b0; m_ready[1] = 1'b0;
    @(negedge aclk);
    chk("hand_vld_b", m_valid[1], 1'b1);
    chk("hand_dat_b", m_data[95:48], 48'hB);
    chk("hand_ovr",   m_ovr[1], 1'b0);
    step(); m_ready[1] = 1'b1;
    step(); m_ready[1] = 1'b0;

    // Mid-run reset drops buffered words
    for (int k = 0; k < 3; k++) begin
      s_valid[0] = 1'b1; s_data[47:0] = 48'h21 + 48'(k);
      step();
    end
    s_valid[0] = 1'b0;
    @(negedge aclk);
    chk("pre_rst_occ", m_occ[2:0], 3'd3);
    step(); aresetn = 1'b0;
    @(negedge aclk);
    chk("in_rst_s_ready", s_ready, 3'b000);
    step(); aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_valid", m_valid[0], 1'b0);
    chk("post_rst_occ",   m_occ[2:0], 3'd0);
    chk("post_rst_ready", s_ready, 3'b111);
    step(); m_ready = 3'b111;
    ndel = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      if (m_valid != 3'b000) ndel++;
      step();
    end
    chk("post_rst_no_word", ndel, 0);
    m_ready = '0;

`ifdef NET_META_STATS_EN
    s_stats = 512'h1234;
    @(negedge aclk);
    chk("stats_lat0", m_stats, 512'h0);
    step(); s_stats = 512'h0;
    @(negedge aclk);
    chk("stats_lat1", m_stats, 512'h1234);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/network_meta_decouple.md
NETWORK_META_DECOUPLE -- requirements
Module: network_meta_decouple

Interface
REQ-001 SHALL have parameter N_CHAN, default 3: number of independent metadata channels, legal range 1..8.
REQ-002 SHALL have parameter DATA_BITS, default 48: per-channel payload width, legal range 1..64.
REQ-003 SHALL have parameter DEPTH, default 4: per-channel FIFO depth, a power of 2 in 2..16.
REQ-004 SHALL have parameter COALESCE, default all zeros, N_CHAN bits: a set bit puts that channel in coalescing mode.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port s_valid, input, N_CHAN bits: per-channel upstream valid.
REQ-008 SHALL have port s_ready, output, N_CHAN bits: per-channel upstream ready.
REQ-009 SHALL have port s_data, input, N_CHAN*DATA_BITS bits: channel i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-010 SHALL have ports m_valid (output, N_CHAN), m_ready (input, N_CHAN) and m_data (output, N_CHAN*DATA_BITS), packed the same way as s_data.
REQ-011 SHALL have port m_occ, output, N_CHAN*($clog2(DEPTH)+1) bits: per-channel registered occupancy.
REQ-012 SHALL have port m_ovr, output, N_CHAN bits: per-channel one-cycle overwrite pulse.
REQ-013 SHALL have ports s_stats (input, 512) and m_stats (output, 512) when NET_META_STATS_EN is defined.

Function
REQ-014 SHALL run all channels independently; there is no arbitration between channels.
REQ-015 FIFO channels SHALL drive s_ready = (occ < DEPTH) from registered state only; there is no combinational path from m_ready to s_ready.
REQ-016 FIFO channels SHALL present a word accepted in cycle t on m_valid/m_data in cycle t+1 at the earliest; the output is registered.
REQ-017 FIFO channels SHALL sustain one transfer per cycle with simultaneous push and pop; occ is unchanged on push+pop.
REQ-018 FIFO channels SHALL wrap read/write pointers modulo DEPTH; occ SHALL be in 0..DEPTH, with DEPTH meaning full.
REQ-019 FIFO channels SHALL, when full, deassert s_ready; a pop in that cycle SHALL raise s_ready in the next cycle, not the same one.
REQ-020 FIFO channels SHALL, when empty, hold m_valid=0; m_data is don't-care while m_valid=0.
REQ-021 FIFO channels SHALL keep m_data stable while m_valid=1 and m_ready=0 (AXI-Stream rule).
REQ-022 Coalescing channels SHALL use a single holding register; s_ready=1 in every cycle outside reset; m_occ is 0 or 1.
REQ-023 Coalescing channels SHALL, on a push while pending with no pop, replace the held value and pulse m_ovr=1 in the next cycle.
REQ-024 Coalescing channels SHALL, on a push and pop in the same cycle, deliver the old value, make the new value pending in the next cycle, and not pulse m_ovr.
REQ-025 Coalescing channels MAY change m_data while m_valid=1 and m_ready=0; this is a deliberate deviation for last-value-wins configuration (IP/MAC address set).
REQ-026 SHALL assert m_ovr only in coalescing mode; it is 0 on FIFO channels.

Reset
REQ-027 SHALL, while aresetn=0 at a rising edge, clear pointers, occ, m_valid, m_ovr and held data-valid flags, and drive s_ready=0.
REQ-028 SHALL drop all buffered words on reset asserted mid-operation, with no partial delivery after reset.
REQ-029 SHALL raise s_ready in the first cycle after aresetn returns to 1.

Configuration
REQ-030 SHALL, with NET_META_STATS_EN defined, register s_stats into m_stats every cycle (latency 1, no handshake), with m_stats reset to 0.
REQ-031 SHALL, without NET_META_STATS_EN, omit the s_stats/m_stats ports and all associated registers.

Verification
REQ-032 The bench SHALL cover: N_CHAN=3, DEPTH=4, FIFO mode, m_ready=0, push 0x11..0x15 on ch0 -> s_ready falls after 4 accepted words, m_occ[ch0]=4, 0x15 is not accepted.
REQ-033 The bench SHALL cover: same setup, then m_ready=1 continuously with s_valid=1 -> output order 0x11,0x12,0x13,0x14,0x15, one word per cycle after the first, and no loss across pointer wrap.
REQ-034 The bench SHALL cover: COALESCE=3'b010, ch1 pushes 0xA, 0xB, 0xC back-to-back with m_ready=0 -> m_ovr[1] pulses twice, and after m_ready=1 exactly one word 0xC is delivered.
REQ-035 The bench SHALL cover: coalescing ch1 pending 0xA, push 0xB in the same cycle as the pop of 0xA -> 0xA delivered, 0xB valid next cycle, m_ovr[1]=0.
REQ-036 The bench SHALL cover: ch0 holding 3 words, aresetn=0 for one cycle -> m_valid=0, m_occ=0, s_ready=0 during reset, s_ready=1 the next cycle, and no old word emitted.
REQ-037 The bench SHALL cover: NET_META_STATS_EN defined, s_stats=512'h1234 in cycle t -> m_stats=512'h1234 in cycle t+1; with the macro undefined, the design elaborates with no stats ports.
